// File: rtl/flag_mon_pkg.sv
// Shared types and default widths for the flag rate monitor.
package flag_mon_pkg;

  typedef enum logic [0:0] {
    FM_IDLE  = 1'b0,
    FM_COUNT = 1'b1
  } fm_state_e;

  localparam int FM_CNT_W  = 8;
  localparam int FM_LOST_W = 8;
  localparam int FM_GAP_W  = 8;

endpackage

// File: rtl/flag_win_timer.sv
// Window timer: counts cycles while run=1 and pulses win_end on the last
// cycle of each WIN_LEN-cycle window, then wraps straight into the next one.
module flag_win_timer
  import flag_mon_pkg::*;
#(
  parameter int WIN_LEN = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic win_end
);

  localparam int TW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam logic [TW-1:0] LAST = TW'(WIN_LEN - 1);

  logic [TW-1:0] tcnt_q, tcnt_d;

  // Advance the window counter; it is held at 0 whenever run is low.
  always_comb begin
    tcnt_d  = '0;
    win_end = 1'b0;
    if (run) begin
      if (tcnt_q == LAST) begin
        win_end = 1'b1;
      end else begin
        tcnt_d = tcnt_q + 1'b1;
      end
    end
  end

  // Window counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt_q <= '0;
    end else begin
      tcnt_q <= tcnt_d;
    end
  end

endmodule

// File: rtl/flag_rate_monitor.sv
// Flag rate monitor: counts one-cycle flag pulses over fixed windows and
// offers each window's result on a valid/ready report buffer. A result that
// completes while the previous report is still unaccepted is dropped and
// tallied in lost_cnt.
// Optional feature: define FLAG_MON_GAP_EN to compile in the longest
// flag-free run measurement (rpt_gap port and GAP_W parameter).
module flag_rate_monitor
  import flag_mon_pkg::*;
#(
  parameter int WIN_LEN = 64,
  parameter int CNT_W   = FM_CNT_W,
  parameter int LOST_W  = FM_LOST_W
`ifdef FLAG_MON_GAP_EN
  , parameter int GAP_W = FM_GAP_W
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              flag,
  input  logic              rpt_ready,
  output logic              rpt_valid,
  output logic [CNT_W-1:0]  rpt_count,
  output logic              rpt_ovf,
  output logic [LOST_W-1:0] lost_cnt
`ifdef FLAG_MON_GAP_EN
  , output logic [GAP_W-1:0] rpt_gap
`endif
);

  fm_state_e         state_q, state_d;
  logic              in_count;
  logic              win_end;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  fin_cnt;
  logic              fin_ovf;

  logic              rpt_valid_q, rpt_valid_d;
  logic [CNT_W-1:0]  rpt_count_q, rpt_count_d;
  logic              rpt_ovf_q, rpt_ovf_d;
  logic [LOST_W-1:0] lost_q, lost_d;
  logic              load;
  logic              drop;

  assign in_count = (state_q == FM_COUNT);

  flag_win_timer #(
    .WIN_LEN (WIN_LEN)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .run     (in_count),
    .win_end (win_end)
  );

  // FSM next state: en starts counting, en low abandons the window.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FM_IDLE:  if (en)  state_d = FM_COUNT;
      FM_COUNT: if (!en) state_d = FM_IDLE;
      default:  state_d = FM_IDLE;
    endcase
  end

  // Flag counting: fin_* include this cycle's flag, so an end-cycle flag
  // belongs to the ending window; counters restart at 0 after window end.
  always_comb begin
    fin_cnt = cnt_q;
    fin_ovf = ovf_q;
    if (flag) begin
      if (&cnt_q) fin_ovf = 1'b1;
      else        fin_cnt = cnt_q + 1'b1;
    end
    cnt_d = '0;
    ovf_d = 1'b0;
    if (in_count && !win_end) begin
      cnt_d = fin_cnt;
      ovf_d = fin_ovf;
    end
  end

  // Report buffer: load when empty or being drained this cycle, otherwise
  // drop the new result and bump the saturating lost counter.
  always_comb begin
    load        = win_end && (!rpt_valid_q || rpt_ready);
    drop        = win_end && rpt_valid_q && !rpt_ready;
    rpt_valid_d = rpt_valid_q;
    rpt_count_d = rpt_count_q;
    rpt_ovf_d   = rpt_ovf_q;
    lost_d      = lost_q;
    if (load) begin
      rpt_valid_d = 1'b1;
      rpt_count_d = fin_cnt;
      rpt_ovf_d   = fin_ovf;
    end else if (rpt_valid_q && rpt_ready) begin
      rpt_valid_d = 1'b0;
    end
    if (drop && !(&lost_q)) begin
      lost_d = lost_q + 1'b1;
    end
  end

  // State, counters and report registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FM_IDLE;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      rpt_valid_q <= 1'b0;
      rpt_count_q <= '0;
      rpt_ovf_q   <= 1'b0;
      lost_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      rpt_valid_q <= rpt_valid_d;
      rpt_count_q <= rpt_count_d;
      rpt_ovf_q   <= rpt_ovf_d;
      lost_q      <= lost_d;
    end
  end

  assign rpt_valid = rpt_valid_q;
  assign rpt_count = rpt_count_q;
  assign rpt_ovf   = rpt_ovf_q;
  assign lost_cnt  = lost_q;

`ifdef FLAG_MON_GAP_EN
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] gmax_q, gmax_d;
  logic [GAP_W-1:0] rpt_gap_q, rpt_gap_d;
  logic [GAP_W-1:0] gap_inc;
  logic [GAP_W-1:0] cand;
  logic [GAP_W-1:0] gmax_fin;

  // Gap tracking: a flag closes the current run at gap_q; a flag-free end
  // cycle closes the trailing run including that cycle (gap_q + 1).
  always_comb begin
    gap_inc  = (&gap_q) ? gap_q : gap_q + 1'b1;
    cand     = flag ? gap_q : gap_inc;
    gmax_fin = gmax_q;
    if ((flag || win_end) && (cand > gmax_q)) begin
      gmax_fin = cand;
    end
    gap_d  = '0;
    gmax_d = '0;
    if (in_count && !win_end) begin
      gap_d  = flag ? '0 : gap_inc;
      gmax_d = gmax_fin;
    end
    rpt_gap_d = load ? gmax_fin : rpt_gap_q;
  end

  // Gap registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      gap_q     <= '0;
      gmax_q    <= '0;
      rpt_gap_q <= '0;
    end else begin
      gap_q     <= gap_d;
      gmax_q    <= gmax_d;
      rpt_gap_q <= rpt_gap_d;
    end
  end

  assign rpt_gap = rpt_gap_q;
`endif

endmodule

// File: tb/tb_flag_rate_monitor.sv
// Directed bench for flag_rate_monitor with WIN_LEN=16, CNT_W=4, LOST_W=4.
// The rpt_gap scenario is compiled in only with FLAG_MON_GAP_EN.
module tb_flag_rate_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       flag;
  logic       rpt_ready;
  logic       rpt_valid;
  logic [3:0] rpt_count;
  logic       rpt_ovf;
  logic [3:0] lost_cnt;
`ifdef FLAG_MON_GAP_EN
  logic [4:0] rpt_gap;
`endif

  int errors = 0;
  int checks = 0;

  flag_rate_monitor #(
    .WIN_LEN (16),
    .CNT_W   (4),
    .LOST_W  (4)
`ifdef FLAG_MON_GAP_EN
    , .GAP_W (5)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .flag      (flag),
    .rpt_ready (rpt_ready),
    .rpt_valid (rpt_valid),
    .rpt_count (rpt_count),
    .rpt_ovf   (rpt_ovf),
    .lost_cnt  (lost_cnt)
`ifdef FLAG_MON_GAP_EN
    , .rpt_gap (rpt_gap)
`endif
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled and inputs changed 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive window cycles start..start+n-1 with flag taken from pat.
  task automatic drive(input logic [15:0] pat, input logic rdy,
                       input int start, input int n);
    for (int k = start; k < start + n; k++) begin
      flag      = pat[k];
      rpt_ready = rdy;
      tick();
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %-22s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; flag = 1'b0; rpt_ready = 1'b0;
    tick(); tick();
    chk("reset_valid", 32'(rpt_valid), 0);
    chk("reset_count", 32'(rpt_count), 0);
    chk("reset_ovf",   32'(rpt_ovf),   0);
    chk("reset_lost",  32'(lost_cnt),  0);

    // Basic count: flags on cycles 0,4,8,12, ready high.
    rst = 1'b0; en = 1'b1; rpt_ready = 1'b1;
    tick();                                  // edge E: en seen
    drive(16'h1111, 1'b1, 0, 15);
    chk("basic_not_yet_valid", 32'(rpt_valid), 0);
    drive(16'h1111, 1'b1, 15, 1);
    chk("basic_valid", 32'(rpt_valid), 1);
    chk("basic_count", 32'(rpt_count), 4);
    chk("basic_ovf",   32'(rpt_ovf),   0);
    drive(16'h1111, 1'b1, 0, 1);
    chk("basic_pulse_one_cycle", 32'(rpt_valid), 0);
    drive(16'h1111, 1'b1, 1, 15);
    chk("basic_repeat_valid", 32'(rpt_valid), 1);
    chk("basic_repeat_count", 32'(rpt_count), 4);

    // Saturation: 16 flags into a 4-bit count, then an empty window.
    drive(16'hFFFF, 1'b1, 0, 16);
    chk("sat_valid", 32'(rpt_valid), 1);
    chk("sat_count", 32'(rpt_count), 15);
    chk("sat_ovf",   32'(rpt_ovf),   1);
    drive(16'h0000, 1'b1, 0, 16);
    chk("sat_next_count", 32'(rpt_count), 0);
    chk("sat_next_ovf",   32'(rpt_ovf),   0);

    // Backpressure: accept pending, then hold ready low over two ends.
    drive(16'h0001, 1'b1, 0, 1);
    drive(16'h0001, 1'b0, 1, 15);
    chk("bp_first_valid", 32'(rpt_valid), 1);
    chk("bp_first_count", 32'(rpt_count), 1);
    drive(16'h0007, 1'b0, 0, 16);
    chk("bp_held_valid", 32'(rpt_valid), 1);
    chk("bp_held_count", 32'(rpt_count), 1);
    chk("bp_lost",       32'(lost_cnt),  1);
    drive(16'h0000, 1'b1, 0, 1);
    chk("bp_accept_valid", 32'(rpt_valid), 0);
    chk("bp_accept_lost",  32'(lost_cnt),  1);
    drive(16'h0000, 1'b1, 1, 15);
    chk("bp_reload_count", 32'(rpt_count), 0);

    // Simultaneous accept and load: ready rises on the window-end cycle.
    drive(16'h0303, 1'b0, 0, 15);
    chk("sim_held_valid", 32'(rpt_valid), 1);
    chk("sim_held_count", 32'(rpt_count), 0);
    drive(16'h0303, 1'b1, 15, 1);
    chk("sim_valid", 32'(rpt_valid), 1);
    chk("sim_count", 32'(rpt_count), 4);
    chk("sim_lost",  32'(lost_cnt),  1);

    // Abort: en drops at window cycle 8; no report and no loss.
    drive(16'h00FF, 1'b1, 0, 8);
    en = 1'b0; flag = 1'b0;
    tick();
    repeat (20) tick();
    chk("abort_valid", 32'(rpt_valid), 0);
    chk("abort_lost",  32'(lost_cnt),  1);

    // Fresh window after re-enable, left pending, then reset.
    en = 1'b1;
    tick();
    drive(16'h0005, 1'b0, 0, 15);
    chk("fresh_not_yet_valid", 32'(rpt_valid), 0);
    drive(16'h0005, 1'b0, 15, 1);
    chk("fresh_valid", 32'(rpt_valid), 1);
    chk("fresh_count", 32'(rpt_count), 2);
    rst = 1'b1;
    tick();
    rst = 1'b0; en = 1'b0;
    chk("rst_valid", 32'(rpt_valid), 0);
    chk("rst_lost",  32'(lost_cnt),  0);
    chk("rst_count", 32'(rpt_count), 0);

`ifdef FLAG_MON_GAP_EN
    // Gap: flags at cycles 2 and 12 -> runs 2, 9, 3.
    en = 1'b1; rpt_ready = 1'b1;
    tick();
    drive(16'h1004, 1'b1, 0, 16);
    chk("gap_valid", 32'(rpt_valid), 1);
    chk("gap_count", 32'(rpt_count), 2);
    chk("gap_value", 32'(rpt_gap),   9);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
